alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external combinational ALU.
// Optional macro ALU_ARB_ILLEGAL_CHK_EN turns sel 101/110/111 into error responses.
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_A,
    input  logic [4*NREQ-1:0] req_B,
    input  logic [3*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [3:0]        rsp_Y,
    output logic              rsp_err,
    output logic [3:0]        alu_A,
    output logic [3:0]        alu_B,
    output logic [2:0]        alu_sel,
    input  logic [3:0]        alu_Y
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t     state;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       handshake;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [2:0] sel_reg;
    logic [3:0] y_reg;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst) begin
            req_ready[grant] = req_valid[grant];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign handshake = req_valid[grant] && req_ready[grant];
    assign alu_A     = a_reg;
    assign alu_B     = b_reg;
    assign alu_sel   = sel_reg;
    assign rsp_Y     = y_reg;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic err_reg;
    assign rsp_err = err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_reg      <= '0;
            b_reg      <= '0;
            sel_reg    <= '0;
            y_reg      <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_reg      <= grant ? req_A[7:4]   : req_A[3:0];
                        b_reg      <= grant ? req_B[7:4]   : req_B[3:0];
                        sel_reg    <= grant ? req_sel[5:3] : req_sel[2:0];
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable on the ALU for a full cycle here.
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                    if (sel_reg >= 3'd5) begin
                        y_reg   <= 4'd0;
                        err_reg <= 1'b1;
                    end else begin
                        y_reg   <= alu_Y;
                        err_reg <= 1'b0;
                    end
`else
                    y_reg <= alu_Y;
`endif
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: external ALU model, arithmetic reference model,
// directed and randomized scenarios.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_A;
    logic [7:0] req_B;
    logic [5:0] req_sel;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_Y;
    logic       rsp_err;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [2:0] alu_sel;
    logic [3:0] alu_Y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_Y(rsp_Y), .rsp_err(rsp_err),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_Y(alu_Y)
    );

    // External ALU; unused encodings return A xor B so pass-through is observable.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_Y = alu_A + alu_B;
            3'd1:    alu_Y = alu_A - alu_B;
            3'd2:    alu_Y = alu_A & alu_B;
            3'd3:    alu_Y = alu_A | alu_B;
            3'd4:    alu_Y = ~alu_A;
            default: alu_Y = alu_A ^ alu_B;
        endcase
    end

    // Expected {err, Y} computed with plain integer arithmetic.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        logic e = 1'b0;
        case (sel)
            3'd0: r = (ia + ib) % 16;
            3'd1: r = (ia - ib + 16) % 16;
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = 15 - ia;
            default: begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                r = 0;
                e = 1'b1;
`else
                r = ia ^ ib;
`endif
            end
        endcase
        return {e, r[3:0]};
    endfunction

    // Drives one transaction on requester r and reports what was observed.
    task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                          input int hold, input bit other_busy,
                          output logic [3:0] y, output logic err, output int lat,
                          output bit stable, output bit done);
        int t;
        y = '0; err = 1'b0; lat = -1; stable = 1'b0; done = 1'b0;
        @(negedge clk);
        rsp_ready = '0;
        req_A[4*r +: 4] = a;
        req_B[4*r +: 4] = b;
        req_sel[3*r +: 3] = sel;
        req_valid[r] = 1'b1;
        t = 0;
        #1;
        while (req_ready[r] !== 1'b1 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 20) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[r] = 1'b0;
        req_A[4*r +: 4] = 4'($urandom);
        req_B[4*r +: 4] = 4'($urandom);
        req_sel[3*r +: 3] = 3'($urandom);
        if (other_busy) req_valid[1-r] = 1'b1;
        lat = 1;
        while (rsp_valid[r] !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++;
        end
        if (lat >= 20) return;
        y = rsp_Y;
        err = rsp_err;
        stable = 1'b1;
        repeat (hold) begin
            rsp_ready[1-r] = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 2'(2'b01 << r) || rsp_Y !== y || rsp_err !== err || req_ready !== 2'b00)
                stable = 1'b0;
        end
        rsp_ready = '0;
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        done = (rsp_valid === 2'b00);
        rsp_ready = '0;
        if (other_busy) req_valid[1-r] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = '0;
        req_A = 8'hA5; req_B = 8'h3C; req_sel = 6'b011010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++;
        if (rsp_Y !== 4'd0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got Y=%h err=%b expected 0/0", rsp_Y, rsp_err); end
        checks++;
        if ({alu_A, alu_B, alu_sel} !== 11'd0) begin errors++; $display("[TB] FAIL reset_alu: got %h %h %b expected 0 0 000", alu_A, alu_B, alu_sel); end
        rst = 1'b0; req_valid = 2'b00;
    endtask

    task automatic test_tie();
        logic [1:0] exp_ready;
        logic [1:0] exp_rsp;
        int g;
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            g = (i / 3) % 2;
            exp_ready = (i % 3 == 0) ? 2'(1 << g) : 2'b00;
            exp_rsp   = (i % 3 == 2) ? 2'(1 << g) : 2'b00;
            checks++;
            if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL tie_ready[%0d]: got %b expected %b", i, req_ready, exp_ready); end
            checks++;
            if (rsp_valid !== exp_rsp) begin errors++; $display("[TB] FAIL tie_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, exp_rsp); end
            @(negedge clk);
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
    endtask

    task automatic test_directed();
        logic [3:0] y; logic e; int lat; bit st; bit dn;
        logic [3:0] exp_y [5] = '{4'b1000, 4'b0010, 4'b0001, 4'b0111, 4'b1010};
        for (int s = 0; s < 5; s++) begin
            run_op((s == 0) ? 0 : 1, 4'b0101, 4'b0011, 3'(s), 0, 1'b0, y, e, lat, st, dn);
            checks++;
            if (y !== exp_y[s] || lat != 2 || !dn) begin
                errors++;
                $display("[TB] FAIL directed_sel%0d: got Y=%b lat=%0d done=%b expected Y=%b lat=2 done=1", s, y, lat, dn, exp_y[s]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] y; logic e; int lat; bit st; bit dn;
        logic [4:0] exp;
        exp = model(4'd9, 4'd12, 3'd1);
        run_op(0, 4'd9, 4'd12, 3'd1, 5, 1'b1, y, e, lat, st, dn);
        checks++;
        if ({e, y} !== exp || lat != 2) begin errors++; $display("[TB] FAIL bp_result: got %b lat=%0d expected %b lat=2", {e, y}, lat, exp); end
        checks++;
        if (!st) begin errors++; $display("[TB] FAIL bp_stable: got 0 expected 1"); end
        checks++;
        if (!dn) begin errors++; $display("[TB] FAIL bp_complete: got 0 expected 1"); end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        req_A[3:0] = 4'd5; req_B[3:0] = 4'd3; req_sel[2:0] = 3'd1; req_valid = 2'b01; rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rx_grant: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({alu_A, alu_B, alu_sel} !== {4'd5, 4'd3, 3'd1}) begin errors++; $display("[TB] FAIL rx_latched: got %h %h %b expected 5 3 001", alu_A, alu_B, alu_sel); end
        rst = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rx_ready_in_rst: got %b expected 00", req_ready); end
        checks++;
        if ({alu_A, alu_B, alu_sel} !== 11'd0) begin errors++; $display("[TB] FAIL rx_alu_cleared: got %h %h %b expected 0 0 000", alu_A, alu_B, alu_sel); end
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rx_no_rsp[%0d]: got %b expected 00", i, rsp_valid); end
            @(negedge clk);
        end
        rsp_ready = 2'b00;
    endtask

    task automatic test_illegal();
        logic [3:0] y; logic e; int lat; bit st; bit dn;
        logic [4:0] exp;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        exp = 5'b1_0000;
`else
        exp = {1'b0, 4'b0110 ^ 4'b1100};
`endif
        run_op(1, 4'b0110, 4'b1100, 3'b111, 1, 1'b0, y, e, lat, st, dn);
        checks++;
        if ({e, y} !== exp || lat != 2 || !dn) begin
            errors++;
            $display("[TB] FAIL illegal_sel: got err/Y=%b lat=%0d done=%b expected %b lat=2 done=1", {e, y}, lat, dn, exp);
        end
    endtask

    task automatic test_random();
        logic [3:0] y; logic e; int lat; bit st; bit dn;
        logic [3:0] a, b; logic [2:0] sel; int r; int hold;
        logic [4:0] exp;
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 1));
            a = 4'($urandom); b = 4'($urandom);
            sel = 3'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            exp = model(a, b, sel);
            run_op(r, a, b, sel, hold, 1'b0, y, e, lat, st, dn);
            checks++;
            if ({e, y} !== exp) begin errors++; $display("[TB] FAIL rand_result[%0d]: got %b expected %b (r=%0d a=%h b=%h sel=%0d)", n, {e, y}, exp, r, a, b, sel); end
            checks++;
            if (lat != 2) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 2", n, lat); end
            checks++;
            if (!st || !dn) begin errors++; $display("[TB] FAIL rand_hold[%0d]: got stable=%b done=%b expected 1/1", n, st, dn); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_tie();
        test_directed();
        test_backpressure();
        test_reset_exec();
        test_illegal();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
